// File: rtl/baser_pkg.sv
// Shared 10GBASE-R definitions: sync headers, scrambler/PRBS31 taps and default seeds.
// Used by the XGMII encoder, the TX scrambler and the RX descrambler.
package baser_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam int SCR_WIDTH = 58;
    localparam int SCR_TAP_A = 39;
    localparam int SCR_TAP_B = 58;

    localparam int PRBS31_WIDTH = 31;
    localparam int PRBS31_TAP_A = 28;
    localparam int PRBS31_TAP_B = 31;

    localparam logic [SCR_WIDTH-1:0]    SCR_SEED_DEFAULT    = 58'h3ff_ffff_ffff_ffff;
    localparam logic [PRBS31_WIDTH-1:0] PRBS31_SEED_DEFAULT = 31'h7fff_ffff;

    typedef enum logic [1:0] {
        MODE_SCRAMBLE,
        MODE_BYPASS,
        MODE_PRBS31
    } tx_mode_e;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Multi-bit advance of a Fibonacci LFSR. Each new bit is din ^ S[n-TAP_A] ^ S[n-TAP_B];
// state holds the last WIDTH generated bits, state[WIDTH-1] being the most recent.
module lfsr_step #(
    parameter int WIDTH = 58,
    parameter int TAP_A = 39,
    parameter int TAP_B = 58,
    parameter int STEPS = 64
) (
    input  logic [WIDTH-1:0] state,
    input  logic [STEPS-1:0] din,
    output logic [STEPS-1:0] dout,
    output logic [WIDTH-1:0] state_next
);

    if (TAP_A > WIDTH || TAP_B > WIDTH || STEPS < WIDTH) begin : g_bad_cfg
        $error("lfsr_step: taps must not exceed WIDTH and STEPS must be >= WIDTH");
    end

    always_comb begin : p_unroll
        logic [WIDTH+STEPS-1:0] hist;
        hist = '0;
        hist[WIDTH-1:0] = state;
        // Bits appended one at a time so later bits see earlier outputs in the same block.
        for (int i = 0; i < STEPS; i++) begin
            hist[WIDTH+i] = din[i] ^ hist[WIDTH+i-TAP_A] ^ hist[WIDTH+i-TAP_B];
        end
        dout       = hist[WIDTH+STEPS-1:WIDTH];
        state_next = hist[WIDTH+STEPS-1 -: WIDTH];
    end

endmodule

// File: rtl/baser_tx_scrambler_64.sv
// 10GBASE-R TX scrambler stage: x^58+x^39+1 self-synchronous payload scrambler,
// scrambler bypass and PRBS31 test pattern, all with one cycle of registered latency.
module baser_tx_scrambler_64
    import baser_pkg::*;
#(
    parameter int                       DATA_WIDTH     = 64,
    parameter int                       HDR_WIDTH      = 2,
    parameter logic [SCR_WIDTH-1:0]     SCRAMBLER_SEED = SCR_SEED_DEFAULT,
    parameter logic [PRBS31_WIDTH-1:0]  PRBS31_SEED    = PRBS31_SEED_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [HDR_WIDTH-1:0]  s_hdr,
    input  logic                  s_valid,
    input  logic                  cfg_bypass,
    input  logic                  cfg_prbs31_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [HDR_WIDTH-1:0]  m_hdr,
    output logic                  m_valid,
    output logic                  stat_hdr_err
);

    localparam int PRBS_STEPS = DATA_WIDTH + HDR_WIDTH;

    if (DATA_WIDTH != 64 || HDR_WIDTH != 2) begin : g_bad_width
        $error("baser_tx_scrambler_64: only DATA_WIDTH=64 and HDR_WIDTH=2 are supported");
    end

    logic [SCR_WIDTH-1:0]    scr_state;
    logic [SCR_WIDTH-1:0]    scr_next;
    logic [DATA_WIDTH-1:0]   scr_out;
    logic [PRBS31_WIDTH-1:0] prbs_state;
    logic [PRBS31_WIDTH-1:0] prbs_cur;
    logic [PRBS31_WIDTH-1:0] prbs_next;
    logic [PRBS_STEPS-1:0]   prbs_out;
    logic                    prbs_en_d;
    tx_mode_e                mode;
    logic [DATA_WIDTH-1:0]   data_sel;
    logic [HDR_WIDTH-1:0]    hdr_sel;

    // Seed is applied combinationally so the first block after enable already starts from it.
    assign prbs_cur = (cfg_prbs31_en && !prbs_en_d) ? PRBS31_SEED : prbs_state;

    lfsr_step #(
        .WIDTH (SCR_WIDTH),
        .TAP_A (SCR_TAP_A),
        .TAP_B (SCR_TAP_B),
        .STEPS (DATA_WIDTH)
    ) u_scr_step (
        .state      (scr_state),
        .din        (s_data),
        .dout       (scr_out),
        .state_next (scr_next)
    );

    lfsr_step #(
        .WIDTH (PRBS31_WIDTH),
        .TAP_A (PRBS31_TAP_A),
        .TAP_B (PRBS31_TAP_B),
        .STEPS (PRBS_STEPS)
    ) u_prbs_step (
        .state      (prbs_cur),
        .din        ('0),
        .dout       (prbs_out),
        .state_next (prbs_next)
    );

    always_comb begin
        mode = MODE_SCRAMBLE;
        if (cfg_prbs31_en) begin
            mode = MODE_PRBS31;
        end else if (cfg_bypass) begin
            mode = MODE_BYPASS;
        end
    end

    always_comb begin
        data_sel = scr_out;
        hdr_sel  = s_hdr;
        case (mode)
            MODE_PRBS31: begin
                hdr_sel  = prbs_out[HDR_WIDTH-1:0];
                data_sel = prbs_out[PRBS_STEPS-1:HDR_WIDTH];
            end
            MODE_BYPASS: data_sel = s_data;
            default:     data_sel = scr_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data       <= '0;
            m_hdr        <= '0;
            m_valid      <= 1'b0;
            stat_hdr_err <= 1'b0;
            scr_state    <= SCRAMBLER_SEED;
            prbs_state   <= PRBS31_SEED;
            prbs_en_d    <= 1'b0;
        end else begin
            prbs_en_d    <= cfg_prbs31_en;
            m_valid      <= s_valid;
            stat_hdr_err <= s_valid && (mode != MODE_PRBS31) && !hdr_is_valid(s_hdr);
            if (s_valid) begin
                m_data <= data_sel;
                m_hdr  <= hdr_sel;
            end
            if (s_valid && mode == MODE_SCRAMBLE) begin
                scr_state <= scr_next;
            end
            if (mode == MODE_PRBS31) begin
                prbs_state <= s_valid ? prbs_next : prbs_cur;
            end
        end
    end

endmodule
